// File: rtl/backend_types.sv
// Shared back-end types: branch tag count, tag index and branch mask typedefs.
package backend_types;

   localparam int unsigned NUM_TAGS  = 4;
   localparam int unsigned TAG_WIDTH = $clog2(NUM_TAGS);

   typedef logic [TAG_WIDTH-1:0] branch_tag_t;
   typedef logic [NUM_TAGS-1:0]  branch_mask_t;

endpackage

// File: rtl/brb_itf.sv
// Branch resolution broadcast bus: one resolver (resp) drives, many holders (req) listen.
interface brb_itf;

   logic                      broadcast;
   backend_types::branch_tag_t tag;
   logic                      clean;

   modport resp (output broadcast, output tag, output clean);
   modport req  (input  broadcast, input  tag, input  clean);

endinterface

// File: rtl/branch_tag_prio_enc.sv
// Lowest-index-first priority encoder over the free-tag vector.
module branch_tag_prio_enc #(
   parameter  int unsigned NUM_TAGS  = 4,
   localparam int unsigned TAG_WIDTH = $clog2(NUM_TAGS)
) (
   input  logic [NUM_TAGS-1:0]  free_mask,
   output logic                 found_c,
   output logic [TAG_WIDTH-1:0] idx_c
);

   always_comb begin
      found_c = 1'b0;
      idx_c   = '0;
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
         if (!found_c && free_mask[i]) begin
            found_c = 1'b1;
            idx_c   = TAG_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/branch_tag_manager.sv
// Branch tag allocator with registered clean/kill broadcast and parent-mask tracking.
// Optional BRANCH_TAG_STATS_EN adds 32-bit clean_count / kill_count outputs.
module branch_tag_manager #(
   parameter  int unsigned NUM_TAGS  = backend_types::NUM_TAGS,
   localparam int unsigned TAG_WIDTH = $clog2(NUM_TAGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_req,
   output logic                 alloc_ready,
   output logic [TAG_WIDTH-1:0] alloc_tag,
   output logic [NUM_TAGS-1:0]  branch_mask,
   input  logic                 resolve_valid,
   input  logic [TAG_WIDTH-1:0] resolve_tag,
   input  logic                 resolve_mispredict,
`ifdef BRANCH_TAG_STATS_EN
   output logic [31:0]          clean_count,
   output logic [31:0]          kill_count,
`endif
   brb_itf.resp                 brif
);

   logic [NUM_TAGS-1:0]  mask_q, mask_d;
   logic [NUM_TAGS-1:0]  parent_q [NUM_TAGS];
   logic [NUM_TAGS-1:0]  parent_d [NUM_TAGS];
   logic                 bc_valid_q, bc_valid_d;
   logic                 bc_clean_q, bc_clean_d;
   logic [TAG_WIDTH-1:0] bc_tag_q, bc_tag_d;

   logic                 clean_active_c, kill_active_c;
   logic [NUM_TAGS-1:0]  bc_onehot_c, release_c, free_mask_c;
   logic                 free_any_c, alloc_fire_c, resolve_ok_c;
   logic [TAG_WIDTH-1:0] free_idx_c;

   assign free_mask_c = ~mask_q;

   branch_tag_prio_enc #(.NUM_TAGS(NUM_TAGS)) u_prio_enc (
      .free_mask (free_mask_c),
      .found_c   (free_any_c),
      .idx_c     (free_idx_c)
   );

   // Tags released at the end of the current broadcast cycle.
   always_comb begin
      clean_active_c = bc_valid_q & bc_clean_q;
      kill_active_c  = bc_valid_q & ~bc_clean_q;
      bc_onehot_c    = '0;
      bc_onehot_c[bc_tag_q] = 1'b1;
      release_c      = '0;
      if (clean_active_c) begin
         release_c = bc_onehot_c;
      end else if (kill_active_c) begin
         release_c = bc_onehot_c;
         for (int j = 0; j < int'(NUM_TAGS); j++) begin
            if (parent_q[j][bc_tag_q]) release_c[j] = 1'b1;
         end
      end
   end

   always_comb begin
      alloc_ready  = free_any_c & ~kill_active_c;
      alloc_tag    = free_idx_c;
      alloc_fire_c = alloc_req & alloc_ready;
      resolve_ok_c = resolve_valid & mask_q[resolve_tag] &
                     ~(kill_active_c & release_c[resolve_tag]);
   end

   // Next state: apply broadcast release first, then the new allocation.
   always_comb begin
      mask_d = mask_q & ~release_c;
      for (int j = 0; j < int'(NUM_TAGS); j++) begin
         parent_d[j] = release_c[j] ? '0 : (parent_q[j] & ~release_c);
      end
      if (alloc_fire_c) begin
         mask_d[free_idx_c]   = 1'b1;
         parent_d[free_idx_c] = mask_q & ~release_c;
      end
      bc_valid_d = resolve_ok_c;
      bc_tag_d   = resolve_ok_c ? resolve_tag         : bc_tag_q;
      bc_clean_d = resolve_ok_c ? ~resolve_mispredict : bc_clean_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q     <= '0;
         bc_valid_q <= 1'b0;
         bc_clean_q <= 1'b0;
         bc_tag_q   <= '0;
         for (int j = 0; j < int'(NUM_TAGS); j++) parent_q[j] <= '0;
      end else begin
         mask_q     <= mask_d;
         bc_valid_q <= bc_valid_d;
         bc_clean_q <= bc_clean_d;
         bc_tag_q   <= bc_tag_d;
         parent_q   <= parent_d;
      end
   end

   assign branch_mask    = mask_q;
   assign brif.broadcast = bc_valid_q;
   assign brif.tag       = backend_types::branch_tag_t'(bc_tag_q);
   assign brif.clean     = bc_clean_q;

`ifdef BRANCH_TAG_STATS_EN
   logic [31:0] clean_count_q, clean_count_d;
   logic [31:0] kill_count_q, kill_count_d;

   always_comb begin
      clean_count_d = clean_count_q + 32'(clean_active_c);
      kill_count_d  = kill_count_q  + 32'(kill_active_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clean_count_q <= '0;
         kill_count_q  <= '0;
      end else begin
         clean_count_q <= clean_count_d;
         kill_count_q  <= kill_count_d;
      end
   end

   assign clean_count = clean_count_q;
   assign kill_count  = kill_count_q;
`endif

endmodule

// File: tb/tb_branch_tag_manager.sv
// Bench for branch_tag_manager (NUM_TAGS=4): directed scenarios plus a randomized run against a set-based model.
module tb_branch_tag_manager;

   logic       clk;
   logic       rst;
   logic       alloc_req;
   logic       alloc_ready;
   logic [1:0] alloc_tag;
   logic [3:0] branch_mask;
   logic       resolve_valid;
   logic [1:0] resolve_tag;
   logic       resolve_mispredict;
`ifdef BRANCH_TAG_STATS_EN
   logic [31:0] clean_count;
   logic [31:0] kill_count;
`endif

   int unsigned chk_cnt;
   int unsigned pass_cnt;

   brb_itf brif_i ();

   branch_tag_manager #(.NUM_TAGS(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .alloc_req          (alloc_req),
      .alloc_ready        (alloc_ready),
      .alloc_tag          (alloc_tag),
      .branch_mask        (branch_mask),
      .resolve_valid      (resolve_valid),
      .resolve_tag        (resolve_tag),
      .resolve_mispredict (resolve_mispredict),
`ifdef BRANCH_TAG_STATS_EN
      .clean_count        (clean_count),
      .kill_count         (kill_count),
`endif
      .brif               (brif_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      alloc_req          = 1'b0;
      resolve_valid      = 1'b0;
      resolve_tag        = 2'd0;
      resolve_mispredict = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc_n(input int n);
      alloc_req = 1'b1;
      repeat (n) tick();
      alloc_req = 1'b0;
   endtask

   task automatic resolve(input logic [1:0] t, input logic mis);
      resolve_valid = 1'b1; resolve_tag = t; resolve_mispredict = mis;
      tick();
      resolve_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      chk_cnt++; if (brif_i.broadcast !== 1'b0) $display("FAIL reset_bc got %0b exp 0", brif_i.broadcast); else pass_cnt++;
      chk_cnt++; if (brif_i.tag !== 2'd0) $display("FAIL reset_tag got %0d exp 0", brif_i.tag); else pass_cnt++;
      chk_cnt++; if (brif_i.clean !== 1'b0) $display("FAIL reset_clean got %0b exp 0", brif_i.clean); else pass_cnt++;
      chk_cnt++; if (branch_mask !== 4'b0000) $display("FAIL reset_mask got %b exp 0000", branch_mask); else pass_cnt++;
      chk_cnt++; if (alloc_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", alloc_ready); else pass_cnt++;
      chk_cnt++; if (alloc_tag !== 2'd0) $display("FAIL reset_alloc_tag got %0d exp 0", alloc_tag); else pass_cnt++;
`ifdef BRANCH_TAG_STATS_EN
      chk_cnt++; if (clean_count !== 32'd0 || kill_count !== 32'd0) $display("FAIL reset_counts got %0d/%0d exp 0/0", clean_count, kill_count); else pass_cnt++;
`endif
   endtask

   task automatic test_fill();
      do_reset();
      alloc_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_cnt++; if (alloc_ready !== 1'b1) $display("FAIL fill_ready[%0d] got %0b exp 1", i, alloc_ready); else pass_cnt++;
         chk_cnt++; if (alloc_tag !== 2'(i)) $display("FAIL fill_tag[%0d] got %0d exp %0d", i, alloc_tag, i); else pass_cnt++;
         tick();
      end
      alloc_req = 1'b0;
      chk_cnt++; if (branch_mask !== 4'b1111) $display("FAIL fill_mask got %b exp 1111", branch_mask); else pass_cnt++;
      chk_cnt++; if (alloc_ready !== 1'b0) $display("FAIL fill_full_ready got %0b exp 0", alloc_ready); else pass_cnt++;
   endtask

   task automatic test_clean();
      do_reset();
      alloc_n(3);
      resolve(2'd1, 1'b0);
      chk_cnt++; if (brif_i.broadcast !== 1'b1 || brif_i.tag !== 2'd1 || brif_i.clean !== 1'b1)
         $display("FAIL clean_bc got bc=%0b tag=%0d clean=%0b exp 1/1/1", brif_i.broadcast, brif_i.tag, brif_i.clean); else pass_cnt++;
      chk_cnt++; if (branch_mask !== 4'b0111) $display("FAIL clean_mask_during got %b exp 0111", branch_mask); else pass_cnt++;
      tick();
      chk_cnt++; if (brif_i.broadcast !== 1'b0) $display("FAIL clean_bc_once got %0b exp 0", brif_i.broadcast); else pass_cnt++;
      chk_cnt++; if (brif_i.tag !== 2'd1 || brif_i.clean !== 1'b1) $display("FAIL clean_hold got tag=%0d clean=%0b exp 1/1", brif_i.tag, brif_i.clean); else pass_cnt++;
      chk_cnt++; if (branch_mask !== 4'b0101) $display("FAIL clean_mask_after got %b exp 0101", branch_mask); else pass_cnt++;
`ifdef BRANCH_TAG_STATS_EN
      chk_cnt++; if (clean_count !== 32'd1) $display("FAIL clean_count got %0d exp 1", clean_count); else pass_cnt++;
`endif
      chk_cnt++; if (alloc_tag !== 2'd1 || alloc_ready !== 1'b1) $display("FAIL clean_regrant got %0d/%0b exp 1/1", alloc_tag, alloc_ready); else pass_cnt++;
      alloc_n(1);
      // Tag 2 must no longer descend from tag 1, so killing the new tag 1 spares it.
      resolve(2'd1, 1'b1);
      chk_cnt++; if (brif_i.broadcast !== 1'b1 || brif_i.clean !== 1'b0) $display("FAIL clean_rekill_bc got %0b/%0b exp 1/0", brif_i.broadcast, brif_i.clean); else pass_cnt++;
      tick();
      chk_cnt++; if (branch_mask !== 4'b0101) $display("FAIL clean_parent got %b exp 0101", branch_mask); else pass_cnt++;
`ifdef BRANCH_TAG_STATS_EN
      chk_cnt++; if (kill_count !== 32'd1) $display("FAIL kill_count got %0d exp 1", kill_count); else pass_cnt++;
`endif
   endtask

   task automatic test_kill();
      do_reset();
      alloc_n(3);
      resolve(2'd1, 1'b1);
      chk_cnt++; if (brif_i.broadcast !== 1'b1 || brif_i.tag !== 2'd1 || brif_i.clean !== 1'b0)
         $display("FAIL kill_bc got bc=%0b tag=%0d clean=%0b exp 1/1/0", brif_i.broadcast, brif_i.tag, brif_i.clean); else pass_cnt++;
      chk_cnt++; if (alloc_ready !== 1'b0) $display("FAIL kill_ready got %0b exp 0", alloc_ready); else pass_cnt++;
      alloc_req = 1'b1;
      resolve(2'd2, 1'b0);
      alloc_req = 1'b0;
      chk_cnt++; if (brif_i.broadcast !== 1'b0) $display("FAIL kill_drop got %0b exp 0", brif_i.broadcast); else pass_cnt++;
      chk_cnt++; if (branch_mask !== 4'b0001) $display("FAIL kill_mask got %b exp 0001", branch_mask); else pass_cnt++;
      chk_cnt++; if (alloc_ready !== 1'b1 || alloc_tag !== 2'd1) $display("FAIL kill_after_ready got %0b/%0d exp 1/1", alloc_ready, alloc_tag); else pass_cnt++;
   endtask

   task automatic test_alloc_on_clean();
      do_reset();
      alloc_n(2);
      resolve(2'd0, 1'b0);
      alloc_req = 1'b1;
      chk_cnt++; if (alloc_tag !== 2'd2) $display("FAIL aoc_tag_during got %0d exp 2", alloc_tag); else pass_cnt++;
      tick();
      chk_cnt++; if (branch_mask !== 4'b0110) $display("FAIL aoc_mask got %b exp 0110", branch_mask); else pass_cnt++;
      chk_cnt++; if (alloc_ready !== 1'b1 || alloc_tag !== 2'd0) $display("FAIL aoc_regrant got %0b/%0d exp 1/0", alloc_ready, alloc_tag); else pass_cnt++;
      tick();
      alloc_req = 1'b0;
      chk_cnt++; if (branch_mask !== 4'b0111) $display("FAIL aoc_mask2 got %b exp 0111", branch_mask); else pass_cnt++;
      // Killing the reissued tag 0 must leave tags 1 and 2 alone.
      resolve(2'd0, 1'b1);
      tick();
      chk_cnt++; if (branch_mask !== 4'b0110) $display("FAIL aoc_parent got %b exp 0110", branch_mask); else pass_cnt++;
   endtask

   task automatic test_reset_mid_broadcast();
      do_reset();
      alloc_n(2);
      resolve(2'd1, 1'b0);
      chk_cnt++; if (brif_i.broadcast !== 1'b1) $display("FAIL rmb_bc_pre got %0b exp 1", brif_i.broadcast); else pass_cnt++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_cnt++; if (brif_i.broadcast !== 1'b0) $display("FAIL rmb_bc got %0b exp 0", brif_i.broadcast); else pass_cnt++;
      chk_cnt++; if (branch_mask !== 4'b0000) $display("FAIL rmb_mask got %b exp 0000", branch_mask); else pass_cnt++;
      chk_cnt++; if (brif_i.tag !== 2'd0 || brif_i.clean !== 1'b0) $display("FAIL rmb_tag got %0d/%0b exp 0/0", brif_i.tag, brif_i.clean); else pass_cnt++;
`ifdef BRANCH_TAG_STATS_EN
      chk_cnt++; if (clean_count !== 32'd0 || kill_count !== 32'd0) $display("FAIL rmb_counts got %0d/%0d exp 0/0", clean_count, kill_count); else pass_cnt++;
`endif
   endtask

   // Model: per-tag outstanding flag and ancestor set, plus the pending broadcast.
   task automatic test_random();
      bit          outs [4];
      bit          anc  [4][4];
      bit          pre  [4];
      bit          vic  [4];
      bit          pv, pc, killing, any_free, acc, req, rv, rm;
      logic [1:0]  pt;
      int          a, rt;
      int unsigned cc, kc;
      logic [3:0]  exp_mask;
      do_reset();
      for (int j = 0; j < 4; j++) begin
         outs[j] = 1'b0;
         for (int k = 0; k < 4; k++) anc[j][k] = 1'b0;
      end
      pv = 1'b0; pc = 1'b0; pt = 2'd0; cc = 0; kc = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         killing  = pv && !pc;
         any_free = 1'b0;
         a        = 0;
         for (int k = 3; k >= 0; k--) if (!outs[k]) begin any_free = 1'b1; a = k; end
         for (int k = 0; k < 4; k++) exp_mask[k] = outs[k];
         chk_cnt++; if (brif_i.broadcast !== pv) $display("FAIL rnd_bc c%0d got %0b exp %0b", cyc, brif_i.broadcast, pv); else pass_cnt++;
         chk_cnt++; if (brif_i.tag !== pt || brif_i.clean !== pc) $display("FAIL rnd_tag c%0d got %0d/%0b exp %0d/%0b", cyc, brif_i.tag, brif_i.clean, pt, pc); else pass_cnt++;
         chk_cnt++; if (branch_mask !== exp_mask) $display("FAIL rnd_mask c%0d got %b exp %b", cyc, branch_mask, exp_mask); else pass_cnt++;
         chk_cnt++; if (alloc_ready !== (any_free && !killing)) $display("FAIL rnd_ready c%0d got %0b exp %0b", cyc, alloc_ready, any_free && !killing); else pass_cnt++;
         if (any_free) begin
            chk_cnt++; if (alloc_tag !== 2'(a)) $display("FAIL rnd_alloc_tag c%0d got %0d exp %0d", cyc, alloc_tag, a); else pass_cnt++;
         end
`ifdef BRANCH_TAG_STATS_EN
         chk_cnt++; if (clean_count !== cc || kill_count !== kc) $display("FAIL rnd_counts c%0d got %0d/%0d exp %0d/%0d", cyc, clean_count, kill_count, cc, kc); else pass_cnt++;
`endif
         req = ($urandom_range(0, 1) == 1);
         rv  = ($urandom_range(0, 3) != 0);
         rt  = int'($urandom_range(0, 3));
         rm  = ($urandom_range(0, 3) == 0);
         alloc_req = req; resolve_valid = rv; resolve_tag = 2'(rt); resolve_mispredict = rm;
         tick();
         acc = rv && outs[rt] && !(killing && (rt == int'(pt) || anc[rt][pt]));
         pre = outs;
         if (pv && pc) begin
            outs[pt] = 1'b0;
            for (int j = 0; j < 4; j++) begin anc[j][pt] = 1'b0; anc[pt][j] = 1'b0; end
            cc++;
         end else if (pv) begin
            for (int j = 0; j < 4; j++) vic[j] = (j == int'(pt)) || anc[j][pt];
            for (int j = 0; j < 4; j++) begin
               if (vic[j]) begin
                  outs[j] = 1'b0;
                  for (int k = 0; k < 4; k++) anc[j][k] = 1'b0;
               end
               for (int k = 0; k < 4; k++) if (vic[k]) anc[j][k] = 1'b0;
            end
            kc++;
         end
         if (req && any_free && !killing) begin
            outs[a] = 1'b1;
            for (int k = 0; k < 4; k++) anc[a][k] = pre[k] && !(pv && pc && k == int'(pt));
         end
         pv = acc;
         if (acc) begin pt = 2'(rt); pc = !rm; end
      end
      idle_inputs();
   endtask

   initial begin
      chk_cnt  = 0;
      pass_cnt = 0;
      rst      = 1'b1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_fill();
      test_clean();
      test_kill();
      test_alloc_on_clean();
      test_reset_mid_broadcast();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/branch_tag_manager.md
BRANCH_TAG_MANAGER -- requirements
Module: branch_tag_manager

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 4, giving the number of outstanding branch tags (power of 2, at least 2).
REQ-002 SHALL have localparam TAG_WIDTH = $clog2(NUM_TAGS), the tag index width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port alloc_req, input, 1, dispatch requests a tag for a branch.
REQ-006 SHALL have port alloc_ready, output, 1, a tag can be granted this cycle.
REQ-007 SHALL have port alloc_tag, output, TAG_WIDTH, the granted tag (lowest-index free tag).
REQ-008 SHALL have port branch_mask, output, NUM_TAGS, the outstanding tags; dispatch attaches this to every new instruction.
REQ-009 SHALL have port resolve_valid, input, 1, the branch unit resolved a branch.
REQ-010 SHALL have port resolve_tag, input, TAG_WIDTH, the tag being resolved.
REQ-011 SHALL have port resolve_mispredict, input, 1, 1 = kill, 0 = clean.
REQ-012 SHALL have port brif, brb_itf.resp modport, driving broadcast, tag and clean to all brb_itf.req holders.

Function
REQ-013 alloc_ready SHALL be 1 iff at least one tag is free and no kill broadcast is active this cycle.
REQ-014 An allocation SHALL occur iff alloc_req & alloc_ready; at that clock edge alloc_tag SHALL become outstanding.
REQ-015 At allocation, the block SHALL record the tag's parent mask as branch_mask at that cycle.
REQ-016 A resolution SHALL be accepted at cycle N iff resolve_valid is 1, resolve_tag is outstanding, and resolve_tag is not being killed or descended from the tag being killed in cycle N; any other resolution SHALL be silently dropped.
REQ-017 An accepted resolution SHALL produce exactly one cycle at N+1 with brif.broadcast=1, brif.tag=resolve_tag and brif.clean=~resolve_mispredict, all registered.
REQ-018 brif.tag and brif.clean SHALL hold their last values when brif.broadcast=0.
REQ-019 Clean, at the end of cycle N+1: the tag SHALL be freed, its branch_mask bit cleared, and its bit cleared in every recorded parent mask.
REQ-020 Kill, at the end of cycle N+1: the tag and every tag whose parent mask contains it SHALL be freed, and all their branch_mask bits cleared.
REQ-021 branch_mask SHALL still contain the resolving tag during the broadcast cycle, so holders clear or kill entries written that cycle.
REQ-022 If an allocation coincides with a clean broadcast, the new tag's parent mask SHALL exclude the cleaned tag.
REQ-023 A freed tag SHALL be allocatable from cycle N+2 onward.
REQ-024 At most one resolution SHALL be accepted per cycle, with no internal queueing.
REQ-025 A tag whose mask bit is 0 SHALL be considered free.

Reset
REQ-026 On rst, the block SHALL free all tags, clear branch_mask and all parent masks, and set brif.broadcast=0, brif.tag=0 and brif.clean=0.
REQ-027 rst asserted mid-broadcast SHALL win, and broadcast SHALL be 0 in the following cycle.

Configuration
REQ-028 With BRANCH_TAG_STATS_EN defined, the block SHALL add 32-bit outputs clean_count and kill_count that increment once per broadcast of each kind, reset to 0, and wrap at 2^32.
REQ-029 Without BRANCH_TAG_STATS_EN, those ports and counters SHALL not exist.

Structure
REQ-030 The branch tag typedef (TAG_WIDTH bits), the mask typedef (NUM_TAGS bits) and NUM_TAGS SHALL live in backend_types.
REQ-031 The lowest-free-tag priority encoder SHALL be one sub-module, branch_tag_prio_enc.

Verification (NUM_TAGS=4)
REQ-032 Reset, then 4 back-to-back allocs -> tags 0,1,2,3 granted, branch_mask=4'b1111, alloc_ready=0 in cycle 5.
REQ-033 Allocate 0,1,2, then resolve tag 1 clean -> broadcast=1, tag=1, clean=1 next cycle only; mask then 4'b0101; tag 2's parent mask becomes 4'b0001.
REQ-034 Allocate 0,1,2, then resolve tag 1 mispredict -> broadcast=1, tag=1, clean=0; alloc_ready=0 that cycle; mask then 4'b0001.
REQ-035 During the kill broadcast of tag 1, resolve tag 2 -> dropped, no broadcast in the following cycle.
REQ-036 Allocation in the same cycle as the clean broadcast of tag 0 -> new tag's parent mask excludes bit 0; tag 0 is regranted two cycles after resolve.
REQ-037 Assert rst during a broadcast cycle -> broadcast=0 and mask=0 next cycle; with BRANCH_TAG_STATS_EN, counters=0.
